// File: rtl/adder_arbiter_if.sv
`default_nettype none
// =============================================================================
// Module      : adder_arbiter_if
// Description : Requester handshake, adder datapath and response bundle for
//               the shared-adder round-robin scheduler.
// Revision    : 1.0 - initial release
// =============================================================================
interface adder_arbiter_if #(
    parameter int INP_DW  = 3,
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*INP_DW-1:0] req_a;
    logic [NUM_REQ*INP_DW-1:0] req_b;
    logic [INP_DW-1:0]         add_inp1;
    logic [INP_DW-1:0]         add_inp2;
    logic [INP_DW:0]           add_outp;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [INP_DW:0]           resp_data;
    logic                      busy;

    // The scheduler itself
    modport slave (
        input  req_valid, req_a, req_b, add_outp,
        output req_ready, add_inp1, add_inp2, resp_valid, resp_data, busy
    );

    // Requesters plus the external adder
    modport master (
        output req_valid, req_a, req_b, add_outp,
        input  req_ready, add_inp1, add_inp2, resp_valid, resp_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : adder_arbiter
// Description : Round-robin scheduler sharing one pipelined adder between
//               NUM_REQ requesters, with a tag pipeline to route sums back.
// Revision    : 1.0 - initial release
// =============================================================================
module adder_arbiter #(
    parameter int INP_DW  = 3,
    parameter int NUM_REQ = 2,
    parameter int ADD_LAT = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    adder_arbiter_if.slave  bus
);
    localparam int c_ptr_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [c_ptr_w-1:0] ptr_q;
    logic [c_ptr_w-1:0] ptr_d;
    logic [ADD_LAT-1:0] vld_q;
    logic [ADD_LAT-1:0] vld_d;
    logic [c_ptr_w-1:0] id_q [ADD_LAT];
    logic [c_ptr_w-1:0] id_d [ADD_LAT];

    logic               w_hi_found;
    logic               w_lo_found;
    logic [c_ptr_w-1:0] w_hi_id;
    logic [c_ptr_w-1:0] w_lo_id;
    logic               w_grant_any;
    logic [c_ptr_w-1:0] w_winner;

    // Two passes: lowest valid index at or above ptr, else lowest valid overall
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_id    = '0;
        w_lo_found = 1'b0;
        w_lo_id    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                w_lo_found = 1'b1;
                w_lo_id    = c_ptr_w'(i);
                if (c_ptr_w'(i) >= ptr_q) begin
                    w_hi_found = 1'b1;
                    w_hi_id    = c_ptr_w'(i);
                end
            end
        end
        w_grant_any = rst & w_lo_found;
        w_winner    = w_hi_found ? w_hi_id : w_lo_id;
    end

    always_comb begin
        bus.req_ready = '0;
        bus.add_inp1  = '0;
        bus.add_inp2  = '0;
        ptr_d         = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_any && (w_winner == c_ptr_w'(i))) begin
                bus.req_ready[i] = 1'b1;
                bus.add_inp1     = bus.req_a[i*INP_DW +: INP_DW];
                bus.add_inp2     = bus.req_b[i*INP_DW +: INP_DW];
                ptr_d            = (i == NUM_REQ - 1) ? '0 : c_ptr_w'(i + 1);
            end
        end
    end

    always_comb begin
        vld_d = '0;
        for (int s = 0; s < ADD_LAT; s++) begin
            id_d[s] = '0;
        end
        vld_d[0] = w_grant_any;
        id_d[0]  = w_winner;
        for (int s = 1; s < ADD_LAT; s++) begin
            vld_d[s] = vld_q[s-1];
            id_d[s]  = id_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
            vld_q <= '0;
            for (int s = 0; s < ADD_LAT; s++) begin
                id_q[s] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            vld_q <= vld_d;
            for (int s = 0; s < ADD_LAT; s++) begin
                id_q[s] <= id_d[s];
            end
        end
    end

    // The last tag stage lines up with the adder output for the same operation
    always_comb begin
        bus.resp_valid = '0;
        bus.resp_data  = '0;
        if (vld_q[ADD_LAT-1]) begin
            bus.resp_data = bus.add_outp;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (id_q[ADD_LAT-1] == c_ptr_w'(i)) begin
                    bus.resp_valid[i] = 1'b1;
                end
            end
        end
    end

    assign bus.busy = |vld_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : tb_adder_arbiter
// Description : Self-checking bench for adder_arbiter with an external adder
//               model and a cycle-level reference of grants and responses.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_adder_arbiter;
    localparam int INP_DW  = 3;
    localparam int NUM_REQ = 2;
    localparam int ADD_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    adder_arbiter_if #(.INP_DW(INP_DW), .NUM_REQ(NUM_REQ)) bus ();

    adder_arbiter #(.INP_DW(INP_DW), .NUM_REQ(NUM_REQ), .ADD_LAT(ADD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // External pipelined adder: ADD_LAT register stages, no reset
    logic [INP_DW:0] add_pipe [ADD_LAT];
    always @(posedge clk) begin
        add_pipe[0] <= {1'b0, bus.add_inp1} + {1'b0, bus.add_inp2};
        for (int s = 1; s < ADD_LAT; s++) add_pipe[s] <= add_pipe[s-1];
    end
    assign bus.add_outp = add_pipe[ADD_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference: round-robin choice and a ring of responses due in future cycles
    int m_ptr = 0;
    int cyc   = 0;
    bit r_vld [8];
    int r_id  [8];
    int r_sum [8];

    always @(negedge clk) begin : model
        int win, idx, slot, a, b;
        bit found, eb;
        logic [NUM_REQ-1:0] e_rdy, e_rv;
        if (!rst) begin
            chk("m_rst_ready", bus.req_ready, 0);
            chk("m_rst_inp1", bus.add_inp1, 0);
            chk("m_rst_inp2", bus.add_inp2, 0);
            chk("m_rst_resp_valid", bus.resp_valid, 0);
            chk("m_rst_resp_data", bus.resp_data, 0);
            chk("m_rst_busy", bus.busy, 0);
            for (int s = 0; s < 8; s++) r_vld[s] = 1'b0;
            m_ptr = 0;
        end else begin
            found = 1'b0;
            win   = 0;
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (m_ptr + k) % NUM_REQ;
                if (!found && bus.req_valid[idx]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
            e_rdy = '0;
            a = 0;
            b = 0;
            if (found) begin
                e_rdy[win] = 1'b1;
                a = int'(bus.req_a[win*INP_DW +: INP_DW]);
                b = int'(bus.req_b[win*INP_DW +: INP_DW]);
            end
            chk("m_ready", bus.req_ready, e_rdy);
            chk("m_inp1", bus.add_inp1, a);
            chk("m_inp2", bus.add_inp2, b);

            slot = cyc % 8;
            e_rv = '0;
            if (r_vld[slot]) e_rv[r_id[slot]] = 1'b1;
            chk("m_resp_valid", bus.resp_valid, e_rv);
            chk("m_resp_data", bus.resp_data, r_vld[slot] ? r_sum[slot] : 0);
            eb = 1'b0;
            for (int j = 0; j < ADD_LAT; j++) eb |= r_vld[(cyc + j) % 8];
            chk("m_busy", bus.busy, eb);
            r_vld[slot] = 1'b0;

            if (found) begin
                r_vld[(cyc + ADD_LAT) % 8] = 1'b1;
                r_id [(cyc + ADD_LAT) % 8] = win;
                r_sum[(cyc + ADD_LAT) % 8] = a + b;
                m_ptr = (win + 1) % NUM_REQ;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input int a0, input int b0, input int a1, input int b1);
        bus.req_valid = v;
        bus.req_a     = {INP_DW'(a1), INP_DW'(a0)};
        bus.req_b     = {INP_DW'(b1), INP_DW'(b0)};
    endtask

    int sums [3];

    initial begin
        sums[0] = 5;
        sums[1] = 6;
        sums[2] = 0;
        drive(2'b11, 1, 1, 1, 1);
        #3;
        chk("reset_ready", bus.req_ready, 0);
        chk("reset_inp1", bus.add_inp1, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_resp_valid", bus.resp_valid, 0);

        // Single request
        step(); step();
        rst = 1'b1;
        drive(2'b01, 3, 4, 0, 0);
        #1 chk("single_ready", bus.req_ready, 2'b01);
        chk("single_inp1", bus.add_inp1, 3);
        step();
        drive(2'b00, 0, 0, 0, 0);
        #1 chk("single_busy_c1", bus.busy, 1);
        step();
        #1 chk("single_resp_valid", bus.resp_valid, 2'b01);
        chk("single_resp_data", bus.resp_data, 7);
        chk("single_busy_c2", bus.busy, 1);
        step();
        #1 chk("single_busy_c3", bus.busy, 0);

        // Contention from reset release
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive((k < 4) ? 2'b11 : 2'b00, 1, 1, 2, 2);
            #1;
            if (k < 4) chk("cont_ready", bus.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k >= 2) begin
                chk("cont_resp_valid", bus.resp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
                chk("cont_resp_data", bus.resp_data, (k % 2 == 0) ? 2 : 4);
            end
            step();
        end

        // Overflow width
        drive(2'b10, 0, 0, 7, 7);
        #1 chk("ovf_ready", bus.req_ready, 2'b10);
        step();
        drive(2'b00, 0, 0, 0, 0);
        step();
        #1 chk("ovf_resp_valid", bus.resp_valid, 2'b10);
        chk("ovf_resp_data", bus.resp_data, 14);
        step();

        // Back-to-back from requester 1
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: drive(2'b10, 0, 0, 2, 3);
                1: drive(2'b10, 0, 0, 3, 3);
                2: drive(2'b10, 0, 0, 0, 0);
                default: drive(2'b00, 0, 0, 0, 0);
            endcase
            #1;
            if (k < 3) chk("b2b_ready", bus.req_ready, 2'b10);
            if (k >= 2) begin
                chk("b2b_resp_valid", bus.resp_valid, 2'b10);
                chk("b2b_resp_data", bus.resp_data, sums[k-2]);
            end
            step();
        end
        drive(2'b11, 1, 1, 1, 1);
        #1 chk("b2b_ptr_zero", bus.req_ready, 2'b01);
        step();
        drive(2'b00, 0, 0, 0, 0);
        step(); step();

        // Reset mid-flight: two grants to requester 0, then reset
        drive(2'b01, 1, 2, 0, 0);
        step();
        drive(2'b01, 3, 3, 0, 0);
        #1 chk("mid_second_ready", bus.req_ready, 2'b01);
        step();
        rst = 1'b0;
        drive(2'b11, 1, 1, 2, 2);
        #1 chk("mid_busy", bus.busy, 0);
        chk("mid_resp_valid", bus.resp_valid, 0);
        chk("mid_ready", bus.req_ready, 0);
        step();
        #1 chk("mid_resp_valid2", bus.resp_valid, 0);
        step();
        rst = 1'b1;
        #1 chk("post_rst_grant", bus.req_ready, 2'b01);
        step();
        drive(2'b00, 0, 0, 0, 0);
        step(); step();

        // Idle: ptr must hold at 1
        for (int k = 0; k < 5; k++) begin
            drive(2'b00, 5, 6, 7, 3);
            #1;
            chk("idle_ready", bus.req_ready, 0);
            chk("idle_inp1", bus.add_inp1, 0);
            chk("idle_inp2", bus.add_inp2, 0);
            chk("idle_resp_valid", bus.resp_valid, 0);
            step();
        end
        drive(2'b11, 1, 1, 2, 2);
        #1 chk("idle_ptr_held", bus.req_ready, 2'b10);
        step();

        // Randomized traffic with occasional resets
        repeat (400) begin
            rst = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
            drive(2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7));
            step();
        end
        rst = 1'b1;
        drive(2'b00, 0, 0, 0, 0);
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin scheduler that shares one `pipelined_adder` instance between `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants at most one requester per cycle and drives the winner's operands onto the adder inputs. A tag pipeline matched to the adder latency steers each sum back to the requester that issued it. It sits between the requesting masters and the adder datapath, which is external to this block.

## Interface
- `INP_DW`, 3, operand width; must equal the adder's `INP_DW`.
- `NUM_REQ`, 2, number of requesters (≥2).
- `ADD_LAT`, 2, cycles from adder input to adder output; must equal the adder's `NUM_REG`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  bit i: requester i has an operand pair.
- `req_ready`  out  NUM_REQ  one-hot or zero; bit i: requester i is granted this cycle.
- `req_a`  in  NUM_REQ*INP_DW  operand A; requester i occupies slice [i*INP_DW +: INP_DW].
- `req_b`  in  NUM_REQ*INP_DW  operand B; same packing as `req_a`.
- `add_inp1`  out  INP_DW  to adder `inp1`.
- `add_inp2`  out  INP_DW  to adder `inp2`.
- `add_outp`  in  INP_DW+1  from adder `outp`.
- `resp_valid`  out  NUM_REQ  one-hot or zero; bit i: `resp_data` belongs to requester i.
- `resp_data`  out  INP_DW+1  sum returned to the requester.
- `busy`  out  1  at least one operation is in flight.

## Operation
- **Handshake.** A transfer on requester i occurs in any cycle where `req_valid[i] && req_ready[i]`. `req_ready` is combinational from `req_valid` and the priority pointer. Requesters must not wait for ready before asserting valid.
- **Arbitration.** `ptr` (clog2(NUM_REQ) bits) names the highest-priority requester.
  - Search order is ptr, ptr+1, …, wrapping modulo NUM_REQ. The first requester with valid set wins.
  - On a grant to i, `ptr` ← (i+1) mod NUM_REQ.
  - With no grant, `ptr` holds.
- **Operand mux.** `add_inp1`/`add_inp2` are combinational: the winner's `req_a`/`req_b` slices, or 0 when there is no grant.
- **Tag pipeline.** The pipeline is ADD_LAT stages deep. Each stage holds {vld, id}.
  - Stage 0 loads {grant_any, winner_id} every cycle.
  - Every other stage shifts unconditionally. There is no stall.
- **Response.**
  - When the last stage has vld=1: `resp_valid` = one-hot(id) and `resp_data` = `add_outp`.
  - When the last stage has vld=0: `resp_valid` = 0 and `resp_data` = 0.
  - Responses cannot be refused; requesters must sink them.
- **busy** = OR of all stage vld bits.
- **Width rule.** The sum is INP_DW+1 bits, produced by the adder and passed through unmodified. The block performs no arithmetic.
- **Reset.** Asserting `rst` low at any time:
  - clears all tag stages (vld=0, id=0) and sets `ptr`=0;
  - discards any in-flight results; their sums never produce `resp_valid`;
  - takes effect immediately (asynchronous). `req_ready` is forced 0 while `rst` is low.

## Timing
- **Latency.** A handshake in cycle t produces its response in cycle t+ADD_LAT (default t+2).
- **Throughput.** One operation per cycle, aggregate across all requesters.
- **Reset values.**
  - `req_ready`=0, `add_inp1`=0, `add_inp2`=0.
  - `resp_valid`=0, `resp_data`=0, `busy`=0.
  - `ptr`=0.
- **Reset release.** Arbitration is live from the first rising edge after `rst` goes high.
- **Fairness.** Under continuous contention from all requesters, each is granted exactly once every NUM_REQ cycles.
- **Simultaneous events.** A response for one requester and a new grant to the same requester may occur in the same cycle. They are independent.
- **Wrap-around.** A grant to NUM_REQ-1 sets `ptr`=0.

## Test plan
- **Single request.** Defaults; requester 0 drives a=3, b=4 in cycle 0.
  - Required: `req_ready`=2'b01 in cycle 0.
  - Required: `resp_valid`=2'b01 and `resp_data`=4'd7 in cycle 2. `busy`=1 in cycles 1–2, then 0.
- **Contention.** Both requesters valid continuously from reset release, requester 0 with a=1, b=1 and requester 1 with a=2, b=2.
  - Required: `req_ready` sequence is 01, 10, 01, 10.
  - Required: two cycles later, `resp_valid` follows the same sequence with `resp_data` alternating 2, 4.
- **Overflow width.** Requester 1 drives a=7, b=7.
  - Required: two cycles later, `resp_valid`=2'b10 and `resp_data`=4'b1110 (14).
- **Back-to-back single requester.** Requester 1 alone for 3 cycles with sums 5, 6, 0.
  - Required: `req_ready`=10 in each of those cycles.
  - Required: three consecutive responses with `resp_valid`=2'b10 carrying 5, 6, 0.
  - Required: `ptr` returns to 0 after each grant.
- **Reset mid-flight.** Two operations are issued; `rst` is pulled low one cycle later for 2 cycles.
  - Required: `busy`=0 and `resp_valid`=0 immediately on assertion, and no response ever appears for those operations.
  - Required: after release, a new request is granted to requester 0 first, because `ptr`=0.
- **Idle.** No `req_valid` for 5 cycles.
  - Required: `req_ready`=0, `add_inp1`/`add_inp2`=0, `resp_valid`=0.
  - Required: `ptr` unchanged from its prior value.
